crack_sched: RTL

CRACK_SCHED -- requirements
Module: crack_sched

---
 rtl/crack_sched_pkg.sv | 14 +
 rtl/crack_rr_arb.sv | 41 ++++
 rtl/crack_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/crack_sched_pkg.sv
// Shared types and constants for the descrack chunk scheduler.
package crack_sched_pkg;

  localparam int KEYW          = 56;
  localparam int CHUNK_LOG_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/crack_rr_arb.sv
// Round-robin picker: one-hot grant starting at the core after the last one granted.
module crack_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          hit;
  int            idx;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    hit     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!hit && req[idx]) begin
        grant[idx] = 1'b1;
        hit        = 1'b1;
        ptr_nxt    = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/crack_sched.sv
// Dispatches key-space chunks to N descrack cores and collects the first match.
// Optional RUN/DRAIN cycle statistics are enabled by defining CRACK_SCHED_STATS_EN.
module crack_sched
  import crack_sched_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int CHUNK_LOG = CHUNK_LOG_DEF,
  localparam int CW        = KEYW - CHUNK_LOG
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            go,
  input  logic            abort,
  input  logic [CW-1:0]   base,
  input  logic [CW-1:0]   limit,
  output logic [N-1:0]    core_run,
  output logic [64*N-1:0] core_start,
  input  logic [N-1:0]    core_busy,
  input  logic [N-1:0]    core_found,
  input  logic [64*N-1:0] core_result,
  output logic            busy,
  output logic            done,
  output logic            found,
  output logic [63:0]     key,
  output logic [CW-1:0]   next_chunk,
  output logic [31:0]     cycles
);

  state_t        state;
  logic [N-1:0]  active;
  logic [N-1:0]  core_busy_p1;
  logic [N-1:0]  fall;
  logic [N-1:0]  hit;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          hit_any;
  logic          launch_ok;
  logic          aborting;
  logic [63:0]   key_sel;

  // Only completions of jobs we launched count; a core still busy from
  // before a reset has active clear, so its result is dropped.
  always_comb begin
    fall      = core_busy_p1 & ~core_busy;
    hit       = fall & active & core_found;
    hit_any   = |hit;
    launch_ok = (state == ST_RUN) && !abort && !hit_any && (next_chunk < limit);
    req       = launch_ok ? (~active & ~core_busy) : '0;
    key_sel   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) key_sel = core_result[i*64 +: 64];
    end
  end

  crack_rr_arb #(.N(N)) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .grant  (grant)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      core_run     <= '0;
      core_start   <= '0;
      active       <= '0;
      core_busy_p1 <= '0;
      aborting     <= 1'b0;
      found        <= 1'b0;
      key          <= '0;
      next_chunk   <= '0;
    end else begin
      core_run     <= grant;
      core_busy_p1 <= core_busy;
      active       <= (active & ~fall) | grant;
      for (int i = 0; i < N; i++) begin
        if (grant[i]) core_start[i*64 +: 64] <= {8'h00, next_chunk, {CHUNK_LOG{1'b0}}};
      end
      if (|grant) next_chunk <= next_chunk + CW'(1);

      case (state)
        ST_IDLE, ST_DONE: begin
          if (go && !abort) begin
            found    <= 1'b0;
            aborting <= 1'b0;
            if (base < limit) begin
              state      <= ST_RUN;
              next_chunk <= base;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            aborting <= 1'b1;
            state    <= ST_DRAIN;
          end else if (hit_any) begin
            key   <= key_sel;
            found <= 1'b1;
            state <= ST_DRAIN;
          end else if (!(next_chunk < limit) && (active == '0)) begin
            state <= ST_DONE;
          end
        end
        ST_DRAIN: begin
          if (active == '0) state <= aborting ? ST_IDLE : ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

`ifdef CRACK_SCHED_STATS_EN
  logic [31:0] cyc_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc_cnt <= '0;
    end else if ((state == ST_IDLE || state == ST_DONE) && go && !abort) begin
      cyc_cnt <= '0;
    end else if (busy) begin
      cyc_cnt <= sat_inc(cyc_cnt);
    end
  end

  assign cycles = cyc_cnt;
`else
  assign cycles = '0;
`endif

endmodule
